// File: rtl/seg_display_pkg.sv
// Shared types and glyph constants for the scrolling 7-segment message display.
// Segments are active-low, bit order a..g = 0..6.
package seg_display_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_SCROLL = 1'b1
   } state_e;

   localparam logic [6:0] SEG_BLANK  = 7'h7F;
   localparam logic [6:0] SEG_APOS   = 7'h7D;
   localparam logic [7:0] CHAR_SPACE = 8'h20;

   localparam logic [6:0] GLYPH_NUM [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   // Letters that have no true 7-segment form use the closest readable shape.
   localparam logic [6:0] GLYPH_ALPHA [26] = '{
      7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h42, 7'h09, 7'h4F,
      7'h61, 7'h0A, 7'h47, 7'h6A, 7'h2B, 7'h23, 7'h0C, 7'h18, 7'h2F,
      7'h12, 7'h07, 7'h41, 7'h63, 7'h55, 7'h09, 7'h11, 7'h24
   };

endpackage

// File: rtl/ascii_seg_lut.sv
// Combinational ASCII to active-low 7-segment glyph lookup.
module ascii_seg_lut
   import seg_display_pkg::*;
(
   input  logic [7:0] char_i,
   output logic [6:0] seg_o
);

   logic [7:0] upper;
   logic [3:0] num_idx;
   logic [4:0] alpha_idx;

   always_comb begin
      upper     = char_i & 8'hDF;
      // Raw 0x00-0x09 and ASCII '0'-'9' share the low nibble as the digit value.
      num_idx   = char_i[3:0];
      alpha_idx = 5'(upper - 8'h41);
      seg_o     = SEG_BLANK;
      if (char_i <= 8'h09 || (char_i >= 8'h30 && char_i <= 8'h39)) begin
         seg_o = GLYPH_NUM[num_idx];
      end else if (upper >= 8'h41 && upper <= 8'h5A) begin
         seg_o = GLYPH_ALPHA[alpha_idx];
      end else if (char_i == 8'h27) begin
         seg_o = SEG_APOS;
      end
   end

endmodule

// File: rtl/ascii_scroll_display.sv
// Message buffer plus right-to-left scroller driving NUM_DIGITS 7-segment digits.
//   state     | meaning
//   ST_IDLE   | buffer editable (clear > start > write), display blank
//   ST_SCROLL | offset advances every TICKS_PER_STEP clocks until stop
module ascii_scroll_display
   import seg_display_pkg::*;
#(
   parameter int NUM_DIGITS     = 6,
   parameter int DEPTH          = 16,
   parameter int TICKS_PER_STEP = 25_000_000
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         wr_en_i,
   input  logic [7:0]                   wr_char_i,
   input  logic                         clear_i,
   input  logic                         start_i,
   input  logic                         stop_i,
   output logic                         busy_o,
   output logic                         full_o,
   output logic [$clog2(DEPTH+1)-1:0]   len_o,
   output logic [7*NUM_DIGITS-1:0]      hex_segs_o
);

   localparam int LEN_W  = $clog2(DEPTH + 1);
   localparam int OFF_W  = $clog2(DEPTH + NUM_DIGITS);
   localparam int TICK_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_e              state_q, state_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [OFF_W-1:0]    offset_q, offset_d;
   logic [TICK_W-1:0]   tick_q, tick_d;
   logic [7:0]          buf_q [DEPTH];
   logic [7*NUM_DIGITS-1:0] segs_q, segs_d;
   logic [7:0]          disp_char [NUM_DIGITS];

   logic is_idle, full, do_clear, do_start, do_write, step_due, at_last;

   assign is_idle  = (state_q == ST_IDLE);
   assign full     = (len_q == LEN_W'(DEPTH));
   assign do_clear = is_idle && clear_i;
   assign do_start = is_idle && !clear_i && start_i && (len_q != '0);
   assign do_write = is_idle && !clear_i && !start_i && wr_en_i && !full;
   assign step_due = (tick_q == TICK_W'(TICKS_PER_STEP - 1));
   assign at_last  = (int'(offset_q) == int'(len_q) + NUM_DIGITS - 1);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (do_start) state_d = ST_SCROLL;
         ST_SCROLL: if (stop_i)   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_o = (state_q == ST_SCROLL);
      for (int d = 0; d < NUM_DIGITS; d++) begin
         int pos;
         // Rightmost digit shows offset-1, leftmost offset-NUM_DIGITS.
         pos          = int'(offset_q) - d - 1;
         disp_char[d] = CHAR_SPACE;
         if (state_q == ST_SCROLL && pos >= 0 && pos < int'(len_q)) begin
            disp_char[d] = buf_q[IDX_W'(pos)];
         end
      end
   end

   always_comb begin
      len_d    = len_q;
      offset_d = offset_q;
      tick_d   = tick_q;
      if (do_clear) begin
         len_d = '0;
      end else if (do_write) begin
         len_d = len_q + LEN_W'(1);
      end
      if (state_q == ST_SCROLL) begin
         if (stop_i) begin
            offset_d = '0;
            tick_d   = '0;
         end else if (step_due) begin
            tick_d   = '0;
            offset_d = at_last ? '0 : offset_q + OFF_W'(1);
         end else begin
            tick_d = tick_q + TICK_W'(1);
         end
      end else begin
         offset_d = '0;
         tick_d   = '0;
      end
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lut
      ascii_seg_lut u_lut (
         .char_i (disp_char[g]),
         .seg_o  (segs_d[7*g +: 7])
      );
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         len_q    <= '0;
         offset_q <= '0;
         tick_q   <= '0;
         segs_q   <= '1;
      end else begin
         len_q    <= len_d;
         offset_q <= offset_d;
         tick_q   <= tick_d;
         segs_q   <= segs_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_write) begin
         buf_q[IDX_W'(len_q)] <= wr_char_i;
      end
   end

   assign full_o     = full;
   assign len_o      = len_q;
   assign hex_segs_o = segs_q;

endmodule

// File: tb/tb_ascii_scroll_display.sv
// Directed scoreboard bench for ascii_scroll_display with 4 digits, depth 4, 3 ticks/step.
module tb_ascii_scroll_display;

   logic        clk_i = 1'b0;
   logic        reset_i, wr_en_i, clear_i, start_i, stop_i;
   logic [7:0]  wr_char_i;
   logic        busy_o, full_o;
   logic [2:0]  len_o;
   logic [27:0] hex_segs_o;

   localparam logic [27:0] BLANK = 28'hFFFFFFF;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      string       tag;
      logic [27:0] segs;
      logic        busy;
      logic        full;
      logic [2:0]  len;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] msg [4];
   int         msg_len = 0;

   ascii_scroll_display #(
      .NUM_DIGITS(4), .DEPTH(4), .TICKS_PER_STEP(3)
   ) dut (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .wr_en_i    (wr_en_i),
      .wr_char_i  (wr_char_i),
      .clear_i    (clear_i),
      .start_i    (start_i),
      .stop_i     (stop_i),
      .busy_o     (busy_o),
      .full_o     (full_o),
      .len_o      (len_o),
      .hex_segs_o (hex_segs_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no finish, expected finish before 1ms");
      $fatal(1, "timeout");
   end

   function automatic logic [6:0] glyph(input logic [7:0] c);
      case (c)
         8'h00, 8'h30: glyph = 7'h40;
         8'h01, 8'h31: glyph = 7'h79;
         8'h02, 8'h32: glyph = 7'h24;
         8'h03, 8'h33: glyph = 7'h30;
         8'h04, 8'h34: glyph = 7'h19;
         8'h05, 8'h35: glyph = 7'h12;
         8'h06, 8'h36: glyph = 7'h02;
         8'h07, 8'h37: glyph = 7'h78;
         8'h08, 8'h38: glyph = 7'h00;
         8'h09, 8'h39: glyph = 7'h10;
         8'h41, 8'h61: glyph = 7'h08;
         8'h48, 8'h68: glyph = 7'h09;
         8'h49, 8'h69: glyph = 7'h4F;
         8'h27:        glyph = 7'h7D;
         default:      glyph = 7'h7F;
      endcase
   endfunction

   // Message padded with four leading blanks; leftmost digit shows pad[k].
   function automatic logic [27:0] window(input int k);
      logic [27:0] r;
      logic [7:0]  c;
      int          j;
      r = '1;
      for (int col = 0; col < 4; col++) begin
         j = k + col;
         c = 8'h20;
         if (j >= 4 && j - 4 < msg_len) c = msg[j - 4];
         r[27 - 7*col -: 7] = glyph(c);
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [27:0] segs, input logic busy,
                       input logic full, input logic [2:0] len);
      exp_t e;
      e.tag = tag; e.segs = segs; e.busy = busy; e.full = full; e.len = len;
      sb.push_back(e);
   endtask

   task automatic step();
      exp_t e;
      @(posedge clk_i);
      #1;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({e.tag, ".segs"}, {4'h0, hex_segs_o}, {4'h0, e.segs});
         chk({e.tag, ".busy"}, {31'h0, busy_o},    {31'h0, e.busy});
         chk({e.tag, ".full"}, {31'h0, full_o},    {31'h0, e.full});
         chk({e.tag, ".len"},  {29'h0, len_o},     {29'h0, e.len});
      end
   endtask

   task automatic wr(input logic [7:0] c, input logic [2:0] exp_len, input logic exp_full);
      wr_en_i   = 1'b1;
      wr_char_i = c;
      push("write", BLANK, 1'b0, exp_full, exp_len);
      step();
      wr_en_i = 1'b0;
   endtask

   initial begin
      logic [27:0] want;
      int          off;

      reset_i   = 1'b0;
      wr_en_i   = 1'($urandom);
      clear_i   = 1'($urandom);
      start_i   = 1'($urandom);
      stop_i    = 1'($urandom);
      wr_char_i = 8'($urandom);
      #3 reset_i = 1'b1;
      #1;
      chk("rst_async.segs", {4'h0, hex_segs_o}, {4'h0, BLANK});
      chk("rst_async.busy", {31'h0, busy_o}, 32'h0);
      chk("rst_async.len",  {29'h0, len_o},  32'h0);
      chk("rst_async.full", {31'h0, full_o}, 32'h0);
      repeat (3) begin
         @(posedge clk_i); #1;
         wr_en_i = 1'($urandom); clear_i = 1'($urandom); start_i = 1'($urandom);
         stop_i  = 1'($urandom); wr_char_i = 8'($urandom);
      end
      chk("rst_hold.segs", {4'h0, hex_segs_o}, {4'h0, BLANK});
      chk("rst_hold.busy", {31'h0, busy_o}, 32'h0);
      chk("rst_hold.len",  {29'h0, len_o},  32'h0);
      @(posedge clk_i); #1;
      reset_i = 1'b0; wr_en_i = 1'b0; clear_i = 1'b0; start_i = 1'b0; stop_i = 1'b0;
      wr_char_i = 8'h00;

      wr("H", 3'd1, 1'b0);
      wr("I", 3'd2, 1'b0);
      wr("J", 3'd3, 1'b0);
      wr("K", 3'd4, 1'b1);
      wr("L", 3'd4, 1'b1);

      clear_i = 1'b1; wr_en_i = 1'b1; wr_char_i = "Z";
      push("clear_wr", BLANK, 1'b0, 1'b0, 3'd0);
      step();
      clear_i = 1'b0; wr_en_i = 1'b0;

      start_i = 1'b1;
      push("start_empty", BLANK, 1'b0, 1'b0, 3'd0);
      step();
      start_i = 1'b0;
      push("start_empty2", BLANK, 1'b0, 1'b0, 3'd0);
      step();

      wr("H", 3'd1, 1'b0);
      wr("I", 3'd2, 1'b0);
      msg[0] = "H"; msg[1] = "I"; msg_len = 2;

      start_i = 1'b1;
      push("start", BLANK, 1'b1, 1'b0, 3'd2);
      step();
      start_i = 1'b0;
      for (int i = 1; i <= 23; i++) begin
         wr_en_i   = (i >= 5 && i <= 7);
         clear_i   = (i >= 5 && i <= 7);
         wr_char_i = "Q";
         off = ((i - 1) / 3) % 6;
         push("scroll_hi", window(off), 1'b1, 1'b0, 3'd2);
         step();
         if (i == 13) chk("off4_left_H", {25'h0, hex_segs_o[27:21]}, 32'h09);
      end
      wr_en_i = 1'b0; clear_i = 1'b0;

      stop_i = 1'b1;
      push("stop_on_step", window(1), 1'b0, 1'b0, 3'd2);
      step();
      stop_i = 1'b0;
      push("stop_idle", BLANK, 1'b0, 1'b0, 3'd2);
      step();

      start_i = 1'b1;
      push("restart", BLANK, 1'b1, 1'b0, 3'd2);
      step();
      start_i = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         push("restart_scroll", window((i - 1) / 3), 1'b1, 1'b0, 3'd2);
         step();
      end
      stop_i = 1'b1;
      push("stop2", window(1), 1'b0, 1'b0, 3'd2);
      step();
      stop_i = 1'b0;

      clear_i = 1'b1;
      push("clear", BLANK, 1'b0, 1'b0, 3'd0);
      step();
      clear_i = 1'b0;
      wr("a", 3'd1, 1'b0);
      wr("5", 3'd2, 1'b0);
      wr(8'h05, 3'd3, 1'b0);
      wr("#", 3'd4, 1'b1);
      msg[0] = "a"; msg[1] = "5"; msg[2] = 8'h05; msg[3] = "#"; msg_len = 4;

      start_i = 1'b1;
      push("start_a5", BLANK, 1'b1, 1'b1, 3'd4);
      step();
      start_i = 1'b0;
      want = {7'h08, 7'h12, 7'h12, 7'h7F};
      for (int i = 1; i <= 13; i++) begin
         off = ((i - 1) / 3) % 8;
         push("scroll_a5", window(off), 1'b1, 1'b1, 3'd4);
         step();
         if (i == 13) chk("off4_a55_blank", {4'h0, hex_segs_o}, {4'h0, want});
      end

      @(negedge clk_i);
      reset_i = 1'b1;
      #1;
      chk("rst_mid.segs", {4'h0, hex_segs_o}, {4'h0, BLANK});
      chk("rst_mid.busy", {31'h0, busy_o}, 32'h0);
      chk("rst_mid.len",  {29'h0, len_o},  32'h0);
      chk("rst_mid.full", {31'h0, full_o}, 32'h0);
      @(posedge clk_i); #1;
      reset_i = 1'b0;
      start_i = 1'b1;
      push("start_after_rst", BLANK, 1'b0, 1'b0, 3'd0);
      step();
      start_i = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
